// File: rtl/systolic_skew_buffer.sv
// Per-lane delay line that skews (lane k delayed k) or deskews (lane k delayed LANES-1-k)
// vectors entering or leaving the PE grid, with a stall input and a tile-drain FSM.
module systolic_skew_buffer #(
   parameter int LANES = 9,
   parameter int DW    = 9,
   parameter int MODE  = 0
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [LANES*DW-1:0]   in_data,
   input  logic                  out_ready,
   output logic [LANES-1:0]      out_valid,
   output logic [LANES*DW-1:0]   out_data,
   output logic                  out_last,
   output logic                  busy
);

   localparam int MAXD = LANES - 1;
   localparam int CW   = $clog2(LANES) + 1;
   localparam logic [CW-1:0] CNT_END = CW'((LANES >= 2) ? LANES - 2 : 0);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic          advance;
   logic          accept;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [LANES-1:0] lane_busy;

   assign advance  = out_ready;
   assign in_ready = out_ready && (state != DRAIN);
   assign accept   = in_valid && in_ready;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam int D = (MODE == 0) ? k : LANES - 1 - k;

      logic [DW-1:0] head_data;
      assign head_data = accept ? in_data[k*DW +: DW] : '0;

      if (D == 0) begin : g_comb
         assign out_valid[k]          = accept;
         assign out_data[k*DW +: DW]  = head_data;
         assign lane_busy[k]          = 1'b0;
      end else begin : g_chain
         logic [D-1:0]  v_q;
         logic [DW-1:0] d_q [D];

         // NOTE: data stages are cleared on reset as well as the valids, because out_data
         // must read zero for every lane whose valid is low, including straight after reset.
         always_ff @(posedge in_clk) begin
            if (in_rst) begin
               v_q <= '0;
               for (int i = 0; i < D; i++) d_q[i] <= '0;
            end else if (advance) begin
               v_q[0] <= accept;
               d_q[0] <= head_data;
               for (int i = 1; i < D; i++) begin
                  v_q[i] <= v_q[i-1];
                  d_q[i] <= d_q[i-1];
               end
            end
         end

         assign out_valid[k]         = v_q[D-1];
         assign out_data[k*DW +: DW] = d_q[D-1];
         assign lane_busy[k]         = |v_q;
      end
   end

   // The last-tag travels alongside the longest lane so it surfaces with the tile's final element.
   if (MAXD == 0) begin : g_tag_comb
      assign out_last = accept && in_last;
   end else begin : g_tag_chain
      logic [MAXD-1:0] tag_q;

      always_ff @(posedge in_clk) begin
         if (in_rst) begin
            tag_q <= '0;
         end else if (advance) begin
            tag_q[0] <= accept && in_last;
            for (int i = 1; i < MAXD; i++) tag_q[i] <= tag_q[i-1];
         end
      end

      assign out_last = tag_q[MAXD-1];
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (advance) begin
         case (state)
            IDLE, RUN: begin
               if (accept) begin
                  if (in_last) begin
                     state <= (LANES > 1) ? DRAIN : IDLE;
                     cnt   <= '0;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            DRAIN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_END) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE) || (|lane_busy);

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Scoreboard bench: SKEW and DESKEW instances with 4 lanes and a single-lane instance,
// driven with directed tiles; a negedge monitor per instance pops expected lane data.
module tb_systolic_skew_buffer;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        s_valid, s_last, s_oready, s_iready, s_olast, s_busy;
   logic [31:0] s_data, s_odata;
   logic [3:0]  s_ovalid;

   logic        d_valid, d_last, d_oready, d_iready, d_olast, d_busy;
   logic [31:0] d_data, d_odata;
   logic [3:0]  d_ovalid;

   logic        o_valid, o_last, o_oready, o_iready, o_olast, o_busy;
   logic [7:0]  o_data, o_odata;
   logic [0:0]  o_ovalid;

   systolic_skew_buffer #(.LANES(4), .DW(8), .MODE(0)) u_skew (
      .in_clk(clk), .in_rst(rst), .in_valid(s_valid), .in_ready(s_iready), .in_last(s_last),
      .in_data(s_data), .out_ready(s_oready), .out_valid(s_ovalid), .out_data(s_odata),
      .out_last(s_olast), .busy(s_busy));

   systolic_skew_buffer #(.LANES(4), .DW(8), .MODE(1)) u_deskew (
      .in_clk(clk), .in_rst(rst), .in_valid(d_valid), .in_ready(d_iready), .in_last(d_last),
      .in_data(d_data), .out_ready(d_oready), .out_valid(d_ovalid), .out_data(d_odata),
      .out_last(d_olast), .busy(d_busy));

   systolic_skew_buffer #(.LANES(1), .DW(8), .MODE(0)) u_one (
      .in_clk(clk), .in_rst(rst), .in_valid(o_valid), .in_ready(o_iready), .in_last(o_last),
      .in_data(o_data), .out_ready(o_oready), .out_valid(o_ovalid), .out_data(o_odata),
      .out_last(o_olast), .busy(o_busy));

   exp_t sq[4][$];
   exp_t dq[4][$];
   exp_t oq[$];
   int   slq[$];
   int   dlq[$];
   int   olq[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got an output, expected none (cycle %0d)", name, cyc);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] vec(input logic [7:0] base);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[k*8 +: 8] = base + 8'(k);
      return r;
   endfunction

   // ---------------- monitors ----------------
   always @(negedge clk) begin : mon_skew
      logic [31:0] m;
      exp_t        e;
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            m[k*8 +: 8] = {8{s_ovalid[k]}};
            if (s_ovalid[k] && s_oready) begin
               if (sq[k].size() == 0) unexpected($sformatf("skew_lane%0d", k));
               else begin
                  e = sq[k].pop_front();
                  check($sformatf("skew_lane%0d_data", k), 32'(s_odata[k*8 +: 8]), 32'(e.data));
                  check($sformatf("skew_lane%0d_cycle", k), cyc, e.cyc);
               end
            end
         end
         check("skew_bubble_zero", s_odata & ~m, 32'h0);
         if (s_olast && s_oready) begin
            if (slq.size() == 0) unexpected("skew_out_last");
            else check("skew_out_last_cycle", cyc, slq.pop_front());
         end
      end
   end

   always @(negedge clk) begin : mon_deskew
      logic [31:0] m;
      exp_t        e;
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            m[k*8 +: 8] = {8{d_ovalid[k]}};
            if (d_ovalid[k] && d_oready) begin
               if (dq[k].size() == 0) unexpected($sformatf("deskew_lane%0d", k));
               else begin
                  e = dq[k].pop_front();
                  check($sformatf("deskew_lane%0d_data", k), 32'(d_odata[k*8 +: 8]), 32'(e.data));
                  check($sformatf("deskew_lane%0d_cycle", k), cyc, e.cyc);
               end
            end
         end
         check("deskew_bubble_zero", d_odata & ~m, 32'h0);
         if (d_olast && d_oready) begin
            if (dlq.size() == 0) unexpected("deskew_out_last");
            else check("deskew_out_last_cycle", cyc, dlq.pop_front());
         end
      end
   end

   always @(negedge clk) begin : mon_one
      exp_t e;
      if (!rst) begin
         if (o_ovalid[0] && o_oready) begin
            if (oq.size() == 0) unexpected("one_lane0");
            else begin
               e = oq.pop_front();
               check("one_lane0_data", 32'(o_odata), 32'(e.data));
               check("one_lane0_cycle", cyc, e.cyc);
            end
         end else begin
            check("one_bubble_zero", 32'(o_odata), 32'h0);
         end
         if (o_olast && o_oready) begin
            if (olq.size() == 0) unexpected("one_out_last");
            else check("one_out_last_cycle", cyc, olq.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   // Three-vector SKEW tile (0x1k, 0x2k, 0x3k), last on the third. Offsets at or beyond
   // stall_at slip by stall_n cycles; offsets at or beyond cut are killed by a reset.
   task automatic tile3(input int stall_at, input int stall_n, input int cut,
                        input bit push_last, input bit post_rst);
      int         c0;
      int         t;
      logic [7:0] b;
      c0 = 0;
      for (int j = 0; j < 3; j++) begin
         next_cycle();
         rst = 1'b0;
         if (j == 0) c0 = cyc;
         b        = 8'((j + 1) * 16);
         s_valid  = 1'b1;
         s_oready = 1'b1;
         s_last   = (j == 2);
         s_data   = vec(b);
         for (int k = 0; k < 4; k++) begin
            t = j + k;
            if (t >= stall_at) t += stall_n;
            if (t < cut) sq[k].push_back('{c0 + t, b + 8'(k)});
         end
         if (j == 2 && push_last) slq.push_back(c0 + 5 + stall_n);
         @(negedge clk);
         check("skew_in_ready_accept", 32'(s_iready), 32'h1);
         if (j == 0 && post_rst) begin
            check("post_rst_out_last", 32'(s_olast), 32'h0);
            check("post_rst_busy", 32'(s_busy), 32'h0);
            check("post_rst_out_valid_hi", 32'(s_ovalid[3:1]), 32'h0);
         end
      end
   endtask

   // Drain tail of an unstalled tile: in_ready low on offsets 3..5, busy drops on offset 6.
   task automatic tile_tail();
      for (int i = 3; i <= 6; i++) begin
         next_cycle();
         s_valid = 1'b0;
         s_last  = 1'b0;
         @(negedge clk);
         check($sformatf("skew_in_ready_off%0d", i), 32'(s_iready), (i < 6) ? 32'h0 : 32'h1);
         if (i >= 5) check($sformatf("skew_busy_off%0d", i), 32'(s_busy), (i == 5) ? 32'h1 : 32'h0);
      end
   endtask

   initial begin
      rst      = 1'b1;
      s_valid  = 1'b1; s_last = 1'b0; s_oready = 1'b1; s_data = vec(8'h55);
      d_valid  = 1'b1; d_last = 1'b0; d_oready = 1'b1; d_data = vec(8'h66);
      o_valid  = 1'b1; o_last = 1'b0; o_oready = 1'b1; o_data = 8'h77;

      // Reset while in_valid and out_ready are high.
      next_cycle();
      next_cycle();
      rst     = 1'b0;
      s_valid = 1'b0; d_valid = 1'b0; o_valid = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(s_ovalid), 32'h0);
      check("rst_out_data", s_odata, 32'h0);
      check("rst_out_last", 32'(s_olast), 32'h0);
      check("rst_busy", 32'(s_busy), 32'h0);
      check("rst_in_ready", 32'(s_iready), 32'h1);
      check("rst_deskew_out_valid", 32'(d_ovalid), 32'h0);

      // Plain SKEW tile.
      tile3(1000, 0, 1000, 1'b1, 1'b0);
      tile_tail();

      // SKEW tile stalled on offsets 4..6 while draining.
      tile3(4, 3, 1000, 1'b1, 1'b0);
      for (int i = 3; i <= 9; i++) begin
         next_cycle();
         s_valid  = 1'b0;
         s_last   = 1'b0;
         s_oready = !(i >= 4 && i <= 6);
         @(negedge clk);
         if (i >= 4 && i <= 6) begin
            check("stall_in_ready", 32'(s_iready), 32'h0);
            check("stall_out_valid", 32'(s_ovalid), 32'hC);
            check("stall_out_data", s_odata, 32'h2332_0000);
            check("stall_out_last", 32'(s_olast), 32'h0);
         end
         if (i == 9) begin
            check("stall_end_busy", 32'(s_busy), 32'h0);
            check("stall_end_in_ready", 32'(s_iready), 32'h1);
         end
      end

      // Reset during DRAIN with cnt=1, then an immediate new tile.
      tile3(1000, 0, 4, 1'b0, 1'b0);
      next_cycle();
      s_valid = 1'b0;
      s_last  = 1'b0;
      next_cycle();
      rst = 1'b1;
      tile3(1000, 0, 1000, 1'b1, 1'b1);
      tile_tail();

      // DESKEW: single vector with last.
      next_cycle();
      d_valid = 1'b1; d_last = 1'b1; d_data = vec(8'hA0);
      for (int k = 0; k < 4; k++) dq[k].push_back('{cyc + 3 - k, 8'hA0 + 8'(k)});
      dlq.push_back(cyc + 3);
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         d_valid = 1'b0; d_last = 1'b0;
         @(negedge clk);
         if (i == 1) check("deskew_in_ready_drain", 32'(d_iready), 32'h0);
         if (i == 4) begin
            check("deskew_in_ready_idle", 32'(d_iready), 32'h1);
            check("deskew_busy_idle", 32'(d_busy), 32'h0);
         end
      end

      // LANES=1: back-to-back vectors with last.
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         o_valid = (i < 2);
         o_last  = (i < 2);
         o_data  = (i == 0) ? 8'h5A : 8'hC3;
         if (i < 2) begin
            oq.push_back('{cyc, o_data});
            olq.push_back(cyc);
         end
         @(negedge clk);
         check("one_in_ready", 32'(o_iready), 32'h1);
         check("one_busy", 32'(o_busy), 32'h0);
      end

      repeat (4) next_cycle();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("skew_lane%0d_missing", k), sq[k].size(), 0);
         check($sformatf("deskew_lane%0d_missing", k), dq[k].size(), 0);
      end
      check("skew_last_missing", slq.size(), 0);
      check("deskew_last_missing", dlq.size(), 0);
      check("one_missing", oq.size(), 0);
      check("one_last_missing", olq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
